// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and sizes for the writeback port arbiter
package wb_arb_pkg;

  localparam int WB_ARB_DEPTH = 2;
  localparam int WB_ARB_CNT_W = $clog2(WB_ARB_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } wb_arb_state_e;

  typedef struct packed {
    logic        live;
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_arb_entry_t;

endpackage

// File: rtl/wb_arb_if.sv
// rtl/wb_arb_if.sv - pipeline, multiplier, hazard and register-file port signals
interface wb_arb_if;

  logic        RegWrite_W;
  logic [4:0]  WriteReg_W;
  logic [31:0] Result_W;
  logic        mul_valid;
  logic [4:0]  mul_dest;
  logic [31:0] mul_data;
  logic        mul_ready;
  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic        raw_stall;
  logic        stall_o;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport slave (
    input  RegWrite_W, WriteReg_W, Result_W,
    input  mul_valid, mul_dest, mul_data,
    output mul_ready,
    input  rs_D, rt_D,
    output raw_stall, stall_o,
    output rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output RegWrite_W, WriteReg_W, Result_W,
    output mul_valid, mul_dest, mul_data,
    input  mul_ready,
    output rs_D, rt_D,
    input  raw_stall, stall_o,
    input  rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_arb_fifo.sv
// rtl/wb_arb_fifo.sv - shift FIFO of multiplier results with squash-by-dest
module wb_arb_fifo
  import wb_arb_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  wb_arb_entry_t                    push_entry,
  input  logic                             pop,
  input  logic                             squash_en,
  input  logic [4:0]                       squash_dest,
  output wb_arb_entry_t                    head,
  output logic [WB_ARB_CNT_W-1:0]          count,
  output logic [WB_ARB_DEPTH-1:0][4:0]     tap_dest,
  output logic [WB_ARB_DEPTH-1:0]          tap_live
);

  localparam int IDX_W = (WB_ARB_DEPTH > 1) ? $clog2(WB_ARB_DEPTH) : 1;

  wb_arb_entry_t           ent     [WB_ARB_DEPTH];
  wb_arb_entry_t           ent_nxt [WB_ARB_DEPTH];
  wb_arb_entry_t           push_kept;
  logic [IDX_W-1:0]        wr_idx;
  logic [WB_ARB_CNT_W-1:0] count_nxt;

  // Squash matching entries first, then shift out the head, then append the new result
  always_comb begin
    ent_nxt = ent;
    for (int i = 0; i < WB_ARB_DEPTH; i++) begin
      if (squash_en && (ent[i].dest == squash_dest)) begin
        ent_nxt[i].live = 1'b0;
      end
    end
    if (pop) begin
      for (int i = 0; i < WB_ARB_DEPTH - 1; i++) begin
        ent_nxt[i] = ent_nxt[i + 1];
      end
      ent_nxt[WB_ARB_DEPTH - 1] = '0;
    end
    push_kept = push_entry;
    if (squash_en && (push_entry.dest == squash_dest)) begin
      push_kept.live = 1'b0;
    end
    wr_idx = IDX_W'(count - WB_ARB_CNT_W'(pop));
    if (push) begin
      ent_nxt[wr_idx] = push_kept;
    end
    count_nxt = count + WB_ARB_CNT_W'(push) - WB_ARB_CNT_W'(pop);
  end

  // Entry storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WB_ARB_DEPTH; i++) begin
        ent[i] <= '0;
      end
      count <= '0;
    end else begin
      ent   <= ent_nxt;
      count <= count_nxt;
    end
  end

  // Per-entry taps; slots beyond the occupancy never report live
  always_comb begin
    for (int i = 0; i < WB_ARB_DEPTH; i++) begin
      tap_dest[i] = ent[i].dest;
      tap_live[i] = ent[i].live && (WB_ARB_CNT_W'(i) < count);
    end
  end

  assign head = ent[0];

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter, starvation drain under WB_ARB_STARVE_EN
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
)
(
  input  logic    clk,
  input  logic    rst_n,
  wb_arb_if.slave bus
);

  localparam logic [3:0] STARVE_LIMIT_W = 4'(STARVE_LIMIT);

  wb_arb_state_e                state;
  wb_arb_state_e                state_nxt;
  wb_arb_entry_t                head;
  wb_arb_entry_t                push_entry;
  logic [WB_ARB_CNT_W-1:0]      count;
  logic [WB_ARB_CNT_W-1:0]      count_nxt;
  logic [WB_ARB_DEPTH-1:0][4:0] tap_dest;
  logic [WB_ARB_DEPTH-1:0]      tap_live;
  logic                         force_mode;
  logic                         head_live;
  logic                         head_dead;
  logic                         pipe_wins;
  logic                         mul_ready_int;
  logic                         push;
  logic                         pop;
  logic                         squash_en;
  logic                         starve_hit;

  // In FORCE the held W stage will re-present its write, so RegWrite_W neither wins the port nor squashes
  assign pipe_wins     = bus.RegWrite_W && !force_mode;
  assign head_live     = (count != '0) && head.live;
  assign head_dead     = (count != '0) && !head.live;
  assign pop           = head_dead || (head_live && !pipe_wins);
  assign mul_ready_int = (count < WB_ARB_CNT_W'(WB_ARB_DEPTH)) && !force_mode;
  assign push          = bus.mul_valid && mul_ready_int;
  assign squash_en     = pipe_wins && (bus.WriteReg_W != 5'd0);
  assign count_nxt     = count + WB_ARB_CNT_W'(push) - WB_ARB_CNT_W'(pop);
  assign push_entry    = '{live: 1'b1, dest: bus.mul_dest, data: bus.mul_data};

  assign bus.mul_ready = mul_ready_int;
  assign bus.stall_o   = force_mode;

  wb_arb_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .squash_en   (squash_en),
    .squash_dest (bus.WriteReg_W),
    .head        (head),
    .count       (count),
    .tap_dest    (tap_dest),
    .tap_live    (tap_live)
  );

`ifdef WB_ARB_STARVE_EN
  logic [3:0] starve_cnt;
  logic [3:0] starve_cnt_nxt;
  logic       blocked;

  assign force_mode = (state == FORCE);
  assign blocked    = (state == PEND) && head_live && bus.RegWrite_W;
  assign starve_hit = blocked && ((starve_cnt + 4'd1) >= STARVE_LIMIT_W);

  // Count consecutive cycles a live head loses the port; any pop restarts the count
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (pop) begin
      starve_cnt_nxt = 4'd0;
    end else if (blocked) begin
      starve_cnt_nxt = starve_cnt + 4'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
    end
  end
`else
  logic unused_starve_limit;

  assign force_mode          = 1'b0;
  assign starve_hit          = 1'b0;
  assign unused_starve_limit = ^STARVE_LIMIT_W;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: leave IDLE on a push, return once the FIFO drains
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (push) begin
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (count_nxt == '0) begin
          state_nxt = IDLE;
        end else if (starve_hit) begin
`ifdef WB_ARB_STARVE_EN
          state_nxt = FORCE;
`else
          state_nxt = PEND;
`endif
        end
      end
`ifdef WB_ARB_STARVE_EN
      FORCE: begin
        if (count_nxt == '0) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Write port mux; register 0 is never written even when a source holds the port
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = 32'd0;
    if (rst_n) begin
      if (pipe_wins) begin
        bus.rf_we    = (bus.WriteReg_W != 5'd0);
        bus.rf_waddr = bus.WriteReg_W;
        bus.rf_wdata = bus.Result_W;
      end else if (head_live) begin
        bus.rf_we    = (head.dest != 5'd0);
        bus.rf_waddr = head.dest;
        bus.rf_wdata = head.data;
      end
    end
  end

  // Decode hazard: a live pending result for either source register
  always_comb begin
    bus.raw_stall = 1'b0;
    for (int i = 0; i < WB_ARB_DEPTH; i++) begin
      if (tap_live[i] && (tap_dest[i] != 5'd0) &&
          ((tap_dest[i] == bus.rs_D) || (tap_dest[i] == bus.rt_D))) begin
        bus.raw_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  wb_arb_if bus();

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_w(input logic [4:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic drive(input logic rw, input logic [4:0] wr, input logic [31:0] res,
                       input logic mv, input logic [4:0] md, input logic [31:0] mdat);
    bus.RegWrite_W = rw;
    bus.WriteReg_W = wr;
    bus.Result_W   = res;
    bus.mul_valid  = mv;
    bus.mul_dest   = md;
    bus.mul_data   = mdat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register-file write must match the next scoreboard entry
  always @(negedge clk) begin
    if (bus.rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got addr=%0d data=%h, expected no write",
                 bus.rf_waddr, bus.rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.rf_waddr, bus.rf_wdata} !== mon_e) begin
          errors++;
          $display("FAIL rf_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   bus.rf_waddr, bus.rf_wdata, mon_e[36:32], mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    // Reset state with busy inputs
    drive(1'b1, 5'd3, 32'hABCD, 1'b1, 5'd6, 32'h66);
    bus.rs_D = 5'd6;
    bus.rt_D = 5'd3;
    @(negedge clk);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rst_rf_wdata", bus.rf_wdata, 32'd0);
    check("rst_mul_ready", 32'(bus.mul_ready), 32'd1);
    check("rst_stall_o", 32'(bus.stall_o), 32'd0);
    check("rst_raw_stall", 32'(bus.raw_stall), 32'd0);
    idle();
    bus.rs_D = 5'd0;
    bus.rt_D = 5'd0;
    step();
    rst_n = 1'b1;

    // Idle pipeline: result written the cycle after acceptance
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    exp_w(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("t2_ready", 32'(bus.mul_ready), 32'd1);
    step();
    idle();
    bus.rt_D = 5'd5;
    @(negedge clk);
    check("t2_raw_rt", 32'(bus.raw_stall), 32'd1);
    step();
    @(negedge clk);
    check("t2_raw_clear", 32'(bus.raw_stall), 32'd0);
    check("t2_ready_idle", 32'(bus.mul_ready), 32'd1);
    step();
    bus.rt_D = 5'd0;

    // Full FIFO while the pipeline owns the port
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 5'd10, 32'h1000 + 32'(k), 1'b1, 5'(k), 32'h11 * 32'(k));
      exp_w(5'd10, 32'h1000 + 32'(k));
      @(negedge clk);
      check("t3_ready", 32'(bus.mul_ready), (k < 3) ? 32'd1 : 32'd0);
      step();
    end
    idle();
    exp_w(5'd1, 32'h11);
    exp_w(5'd2, 32'h22);
    @(negedge clk);
    check("t3_ready_pop_full", 32'(bus.mul_ready), 32'd0);
    step();
    @(negedge clk);
    check("t3_ready_one", 32'(bus.mul_ready), 32'd1);
    step();

    // WAW squash of a pending entry
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    step();
    drive(1'b1, 5'd7, 32'h700, 1'b0, 5'd0, 32'd0);
    bus.rs_D = 5'd7;
    exp_w(5'd7, 32'h700);
    @(negedge clk);
    check("t4_raw_before", 32'(bus.raw_stall), 32'd1);
    step();
    idle();
    @(negedge clk);
    check("t4_raw_after", 32'(bus.raw_stall), 32'd0);
    check("t4_no_write", 32'(bus.rf_we), 32'd0);
    step();

    // Squash of a result accepted in the same cycle
    drive(1'b1, 5'd9, 32'h900, 1'b1, 5'd9, 32'h99);
    exp_w(5'd9, 32'h900);
    step();
    idle();
    bus.rs_D = 5'd9;
    @(negedge clk);
    check("t5_raw", 32'(bus.raw_stall), 32'd0);
    check("t5_no_write", 32'(bus.rf_we), 32'd0);
    step();
    bus.rs_D = 5'd0;

    // Register 0: pipeline write holds the port, dest 0 result drains silently
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
    step();
    drive(1'b1, 5'd0, 32'h123, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("t6_pipe_r0", 32'(bus.rf_we), 32'd0);
    step();
    idle();
    exp_w(5'd4, 32'h44);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    step();
    idle();
    @(negedge clk);
    check("t6_dest0", 32'(bus.rf_we), 32'd0);
    step();

    // Starvation under a continuous pipeline write stream
    drive(1'b1, 5'd20, 32'h2000, 1'b1, 5'd12, 32'hC0DE);
    exp_w(5'd20, 32'h2000);
    step();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'd20, 32'h2000 + 32'(k), 1'b0, 5'd0, 32'd0);
      exp_w(5'd20, 32'h2000 + 32'(k));
      @(negedge clk);
      check("t7_no_stall", 32'(bus.stall_o), 32'd0);
      step();
    end
`ifdef WB_ARB_STARVE_EN
    drive(1'b1, 5'd20, 32'h2005, 1'b1, 5'd15, 32'hF);
    exp_w(5'd12, 32'hC0DE);
    @(negedge clk);
    check("t7_stall", 32'(bus.stall_o), 32'd1);
    check("t7_ready_force", 32'(bus.mul_ready), 32'd0);
    step();
    drive(1'b1, 5'd20, 32'h2005, 1'b0, 5'd0, 32'd0);
    exp_w(5'd20, 32'h2005);
    @(negedge clk);
    check("t7_stall_drop", 32'(bus.stall_o), 32'd0);
    step();
`else
    drive(1'b1, 5'd20, 32'h2005, 1'b0, 5'd0, 32'd0);
    exp_w(5'd20, 32'h2005);
    @(negedge clk);
    check("t7_stall_off", 32'(bus.stall_o), 32'd0);
    step();
    idle();
    exp_w(5'd12, 32'hC0DE);
    @(negedge clk);
    check("t7_stall_off_drain", 32'(bus.stall_o), 32'd0);
    step();
`endif
    idle();
    step();

    // Reset with two pending results
    drive(1'b1, 5'd21, 32'h2100, 1'b1, 5'd13, 32'hD1);
    exp_w(5'd21, 32'h2100);
    step();
    drive(1'b1, 5'd22, 32'h2200, 1'b1, 5'd14, 32'hD2);
    exp_w(5'd22, 32'h2200);
    step();
    drive(1'b1, 5'd23, 32'h2300, 1'b0, 5'd0, 32'd0);
    bus.rs_D = 5'd13;
    #1;
    check("t8_full", 32'(bus.mul_ready), 32'd0);
    check("t8_raw_pending", 32'(bus.raw_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t8_rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("t8_rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("t8_rst_rf_wdata", bus.rf_wdata, 32'd0);
    check("t8_rst_stall_o", 32'(bus.stall_o), 32'd0);
    check("t8_rst_raw", 32'(bus.raw_stall), 32'd0);
    check("t8_rst_ready", 32'(bus.mul_ready), 32'd1);
    idle();
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t8_post_raw", 32'(bus.raw_stall), 32'd0);
      step();
    end

    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, number of blocked cycles before the arbiter forces a drain (range 1..15).
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 RegWrite_W  in  1  the pipeline writeback stage requests the register-file write port.
REQ-005 WriteReg_W  in  5  pipeline destination register.
REQ-006 Result_W  in  32  pipeline write data.
REQ-007 mul_valid  in  1  the multi-cycle multiplier offers a result.
REQ-008 mul_dest  in  5  multiplier destination register.
REQ-009 mul_data  in  32  multiplier result.
REQ-010 mul_ready  out  1  a multiplier result is accepted when mul_valid and mul_ready are both high.
REQ-011 rs_D, rt_D  in  5 each  decode-stage source registers for the hazard check.
REQ-012 raw_stall  out  1  a decode source matches a pending multiplier result.
REQ-013 stall_o  out  1  freezes the M/W pipeline registers.
REQ-014 rf_we, rf_waddr, rf_wdata  out  1/5/32  register-file write port.

Function
REQ-015 Buffering: a 2-entry FIFO holds accepted results; each entry stores {live, dest, data}.
- mul_ready = (count < 2).
- This signal has no combinational path from the same-cycle pop.
REQ-016 Minimum latency: no bypass; an accepted result reaches rf_we no earlier than the cycle after acceptance.
REQ-017 Port priority outside FORCE:
- If RegWrite_W=1, the port carries the pipeline write.
- Otherwise, if the head entry is live, the port carries the head entry and the head is popped.
- Otherwise rf_we=0.
REQ-018 A dest=0 write never asserts rf_we.
- A pipeline write with WriteReg_W=0 still occupies the port.
REQ-019 WAW squash: a pipeline write with RegWrite_W=1 and WriteReg_W≠0 clears live on every stored entry with an equal dest.
- A result accepted in the same cycle with an equal dest is stored with live=0.
REQ-020 A head entry with live=0 is popped at the next edge without writing, regardless of port use.
REQ-021 Simultaneous push and pop in one cycle is legal; count is unchanged.
REQ-022 raw_stall = 1 when any live entry has dest≠0 equal to rs_D or rt_D; the signal is combinational.
REQ-023 FSM states:
- IDLE: FIFO empty.
- PEND: one or more entries present.
- FORCE: draining under stall.
REQ-024 FSM transitions:
- IDLE→PEND on a push.
- PEND→IDLE when count becomes 0.
- PEND→FORCE per REQ-026.
- FORCE→IDLE when count becomes 0.
REQ-025 In FORCE:
- stall_o=1.
- The port carries the head entry every cycle.
- RegWrite_W is ignored, because the held W stage re-presents its write after FORCE.
- mul_ready=0.
REQ-026 Starvation counter (4 bits):
- Increments each PEND cycle in which a live head is blocked by RegWrite_W.
- Clears on any pop.
- Reaching STARVE_LIMIT moves PEND→FORCE at that edge.

Reset
REQ-027 While rst_n=0:
- state=IDLE, count=0, all entries cleared, starvation counter=0.
- stall_o, rf_we, rf_waddr, rf_wdata and raw_stall are 0; mul_ready=1.
REQ-028 Reset mid-operation discards pending results without writing them.
REQ-029 The first edge after release behaves as from IDLE.

Configuration
REQ-030 Macro WB_ARB_STARVE_EN.
- Defined: REQ-026 applies as written.
- Undefined: the starvation counter and the FORCE state are removed; stall_o is tied to 0; entries drain only on cycles with RegWrite_W=0.

Structure
REQ-031 The shared package wb_arb_pkg holds:
- the state enum (IDLE, PEND, FORCE);
- WB_ARB_DEPTH=2;
- the entry struct {live, dest[4:0], data[31:0]}.
REQ-032 The FIFO is the sub-module wb_arb_fifo, which provides push, pop, squash-by-dest, head, count and per-entry dest/live taps; the FSM stays in wb_port_arbiter.

Verification
REQ-033 Idle pipeline:
- Stimulus: push {dest=5, data=0xDEADBEEF}.
- Response: the next cycle has rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; state returns to IDLE.
REQ-034 Full FIFO:
- Stimulus: two pushes with RegWrite_W held 1.
- Response: mul_ready=0 with count=2; a third mul_valid is not accepted.
REQ-035 WAW squash:
- Stimulus: entry dest=7 pending, then a pipeline write to register 7.
- Response: the entry is popped without an rf write; raw_stall for rs_D=7 drops.
REQ-036 Starvation:
- Stimulus: STARVE_LIMIT=4, RegWrite_W held 1 with a live entry pending.
- Response: stall_o=1 after 4 blocked cycles; the entry is written; stall_o drops the cycle after the FIFO empties.
REQ-037 Reset mid-operation:
- Stimulus: rst_n low while count=2.
- Response: immediately all outputs are 0 except mul_ready=1; no rf writes occur after release.
